// File: rtl/shared_bus_pkg.sv
// Shared types and helpers for the shared-bus arbiter and its round-robin picker.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // Owner index width; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: search starts just after ptr and
// wraps, so the requester at ptr has the lowest priority.
module rr_pick
  import shared_bus_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OW    = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    winner,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner arbiter for the shared tristate bus: registered one-hot
// driver enables, bounded tenure, and a dead interval between owners.
module shared_bus_arbiter
  import shared_bus_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            drv_en,
  output logic [owner_w(N_REQ)-1:0]   bus_owner,
  output logic [DATA_W-1:0]           bus_data,
  output logic                        bus_valid,
  output state_t                      dbg_state
);

  localparam int OW = owner_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND);

  // Handshake: req is a level held by a requester for as long as it wants the
  // bus; drv_en[i] high means requester i may drive this cycle. There is no
  // per-beat ready: ownership ends when req drops or the hold budget preempts.

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   drv_en_q, drv_en_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [TW-1:0]      turn_q, turn_d;

  logic [OW-1:0]      winner;
  logic               any_req;
  logic [N_REQ-1:0]   owner_oh;
  logic               others_req;
  logic               do_grant;
  logic               do_release;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_oh   = N_REQ'(1) << owner_q;
  assign others_req = |(req & ~owner_oh);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    drv_en_d   = drv_en_q;
    data_d     = data_q;
    valid_d    = valid_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    do_grant   = 1'b0;
    do_release = 1'b0;

    unique case (state_q)
      IDLE: begin
        drv_en_d = '0;
        valid_d  = 1'b0;
        do_grant = any_req;
      end
      OWN: begin
        if (!req[owner_q]) begin
          do_release = 1'b1;
        end else if (hold_q == HOLD_MAX && others_req) begin
          do_release = 1'b1;
        end else begin
          data_d   = req_data[int'(owner_q)*DATA_W +: DATA_W];
          valid_d  = 1'b1;
          drv_en_d = owner_oh;
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        end
      end
      TURN: begin
        drv_en_d = '0;
        valid_d  = 1'b0;
        if (turn_q == TURN_LAST) begin
          if (any_req) do_grant = 1'b1;
          else         state_d  = IDLE;
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_release) begin
      state_d  = TURN;
      drv_en_d = '0;
      valid_d  = 1'b0;
      turn_d   = TW'(1);
    end

    // The previous owner sits at ptr, so it is eligible but ranked last.
    if (do_grant) begin
      state_d  = OWN;
      owner_d  = winner;
      ptr_d    = winner;
      drv_en_d = N_REQ'(1) << winner;
      data_d   = req_data[int'(winner)*DATA_W +: DATA_W];
      valid_d  = 1'b1;
      hold_d   = HW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= OW'(N_REQ - 1);
      drv_en_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      turn_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      drv_en_q <= drv_en_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
    end
  end

  assign drv_en    = drv_en_q;
  assign bus_owner = owner_q;
  assign bus_data  = data_q;
  assign bus_valid = valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter: directed scenarios plus random
// traffic checked against a tenure/gap reference model.
module tb_shared_bus_arbiter;
  import shared_bus_pkg::*;

  localparam int N_REQ      = 4;
  localparam int DATA_W     = 8;
  localparam int MAX_HOLD   = 4;
  localparam int TURNAROUND = 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] req_data = '0;
  logic [N_REQ-1:0]        drv_en;
  logic [1:0]              bus_owner;
  logic [DATA_W-1:0]       bus_data;
  logic                    bus_valid;
  state_t                  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  shared_bus_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_W     (DATA_W),
    .MAX_HOLD   (MAX_HOLD),
    .TURNAROUND (TURNAROUND)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_data  (req_data),
    .drv_en    (drv_en),
    .bus_owner (bus_owner),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .dbg_state (dbg_state)
  );

  // Reference model: an owner is either holding (m_valid), in a dead gap
  // (m_gap cycles left), or absent; picks scan from the last owner onward.
  int         m_owner = 0;
  int         m_last  = N_REQ - 1;
  int         m_held  = 0;
  int         m_gap   = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = '0;

  function automatic int model_pick(input logic [N_REQ-1:0] r, input int last);
    for (int i = 1; i <= N_REQ; i++) begin
      if (r[(last + i) % N_REQ]) return (last + i) % N_REQ;
    end
    return last;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= 0;
      m_last  <= N_REQ - 1;
      m_held  <= 0;
      m_gap   <= 0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (m_valid) begin
      if (!req[m_owner] ||
          (m_held >= MAX_HOLD && (req & ~(4'b0001 << m_owner)) != 0)) begin
        m_valid <= 1'b0;
        m_gap   <= TURNAROUND;
      end else begin
        m_data <= req_data[m_owner*DATA_W +: DATA_W];
        m_held <= (m_held + 1 > MAX_HOLD) ? MAX_HOLD : m_held + 1;
      end
    end else if (m_gap > 1) begin
      m_gap <= m_gap - 1;
    end else begin
      m_gap <= 0;
      if (req != 0) begin
        m_owner <= model_pick(req, m_last);
        m_last  <= model_pick(req, m_last);
        m_data  <= req_data[model_pick(req, m_last)*DATA_W +: DATA_W];
        m_valid <= 1'b1;
        m_held  <= 1;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_idle();
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    repeat (3) tick();
    checks++; if (drv_en !== 4'b0000) begin errors++; $display("FAIL reset_drv_en got %b want 0000", drv_en); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_valid); end
    checks++; if (bus_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus_data); end
    checks++; if (bus_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", bus_owner); end
    reset_n = 1'b1;
    tick();
    checks++; if (drv_en !== 4'b0001) begin errors++; $display("FAIL first_grant_drv got %b want 0001", drv_en); end
    checks++; if (bus_owner !== 2'd0) begin errors++; $display("FAIL first_grant_owner got %0d want 0", bus_owner); end
    checks++; if (bus_data !== 8'h11) begin errors++; $display("FAIL first_grant_data got %h want 11", bus_data); end
    req = '0;
    tick();
    tick();
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_back_idle got %0d want %0d", dbg_state, IDLE); end
  endtask

  task automatic test_single_owner();
    req_data = 32'h00A50000;
    req      = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (drv_en !== 4'b0100 || bus_valid !== 1'b1 || bus_data !== 8'hA5) begin
        errors++; $display("FAIL single_cycle%0d got drv=%b v=%b d=%h want 0100 1 a5", c, drv_en, bus_valid, bus_data);
      end
    end
    req = '0;
    tick();
    checks++; if (drv_en !== 4'b0000 || bus_valid !== 1'b0) begin errors++; $display("FAIL single_release got drv=%b v=%b want 0000 0", drv_en, bus_valid); end
    checks++; if (dbg_state !== TURN) begin errors++; $display("FAIL single_turn got %0d want %0d", dbg_state, TURN); end
    tick();
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL single_idle got %0d want %0d", dbg_state, IDLE); end
    checks++; if (bus_owner !== 2'd2) begin errors++; $display("FAIL single_owner_hold got %0d want 2", bus_owner); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_owner;
    logic [3:0] want;
    reset_n = 1'b0;
    tick();
    reset_n  = 1'b1;
    exp_q    = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    req_data = 32'h13121110;
    req      = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_owner = exp_q.pop_front();
      want      = 4'b0001 << exp_owner;
      for (int c = 0; c < MAX_HOLD; c++) begin
        tick();
        checks++; if ($countones(drv_en) > 1) begin errors++; $display("FAIL rot_multihot got %b", drv_en); end
        checks++; if (drv_en !== want || bus_valid !== 1'b1 || bus_data !== (8'h10 + 8'(exp_owner))) begin
          errors++; $display("FAIL rot_t%0d_c%0d got drv=%b v=%b d=%h want %b 1 %h", t, c, drv_en, bus_valid, bus_data, want, 8'h10 + 8'(exp_owner));
        end
      end
      if (t < 4) begin
        tick();
        checks++; if (drv_en !== 4'b0000 || bus_valid !== 1'b0) begin errors++; $display("FAIL rot_gap%0d got drv=%b v=%b want 0000 0", t, drv_en, bus_valid); end
      end
    end
    go_idle();
  endtask

  task automatic test_lone_requester();
    logic [7:0] d;
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      d        = 8'($urandom_range(0, 255));
      req_data = {16'h0, d, 8'h0};
      tick();
      checks++; if (drv_en !== 4'b0010 || bus_valid !== 1'b1 || bus_data !== d) begin
        errors++; $display("FAIL lone_c%0d got drv=%b v=%b d=%h want 0010 1 %h", c, drv_en, bus_valid, bus_data, d);
      end
    end
    go_idle();
  endtask

  task automatic test_preempt();
    req_data = 32'h43002100;
    req      = 4'b0010;
    tick();
    tick();
    req = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (drv_en !== 4'b0010 || bus_valid !== 1'b1) begin errors++; $display("FAIL preempt_extra%0d got drv=%b v=%b want 0010 1", c, drv_en, bus_valid); end
    end
    tick();
    checks++; if (drv_en !== 4'b0000 || bus_valid !== 1'b0) begin errors++; $display("FAIL preempt_gap got drv=%b v=%b want 0000 0", drv_en, bus_valid); end
    tick();
    checks++; if (drv_en !== 4'b1000 || bus_owner !== 2'd3 || bus_data !== 8'h43) begin
      errors++; $display("FAIL preempt_new got drv=%b own=%0d d=%h want 1000 3 43", drv_en, bus_owner, bus_data);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick();
    tick();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (drv_en !== 4'b0000 || bus_valid !== 1'b0) begin errors++; $display("FAIL async_clear got drv=%b v=%b want 0000 0", drv_en, bus_valid); end
    @(negedge clk);
    req     = 4'b1010;
    reset_n = 1'b1;
    tick();
    checks++; if (drv_en !== 4'b0010 || bus_owner !== 2'd1) begin errors++; $display("FAIL async_first got drv=%b own=%0d want 0010 1", drv_en, bus_owner); end
    go_idle();
  endtask

  task automatic test_random();
    logic [3:0] want;
    logic [3:0] prev_drv;
    int         shown;
    prev_drv = drv_en;
    shown    = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      req_data = $urandom();
      tick();
      want = m_valid ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (drv_en !== want || bus_valid !== m_valid || bus_data !== m_data || bus_owner !== 2'(m_owner)) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL rand_c%0d got drv=%b v=%b d=%h own=%0d want %b %b %h %0d",
                   c, drv_en, bus_valid, bus_data, bus_owner, want, m_valid, m_data, m_owner);
        end
      end
      checks++; if ($countones(drv_en) > 1 || (prev_drv != 0 && drv_en != 0 && prev_drv != drv_en)) begin
        errors++; $display("FAIL rand_overlap_c%0d got prev=%b now=%b", c, prev_drv, drv_en);
      end
      prev_drv = drv_en;
    end
  endtask

  initial begin
    test_reset();
    test_single_owner();
    test_rotation();
    test_lone_requester();
    test_preempt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
